// File: rtl/hilo_muldiv_if.sv
// Op codes shared with the ALU decoder, plus the EX-stage bus between the pipeline and the HI/LO unit.
package hilo_muldiv_pkg;
  localparam logic [7:0] MTHI_CONTROL  = 8'b0001_0001;
  localparam logic [7:0] MTLO_CONTROL  = 8'b0001_0011;
  localparam logic [7:0] MULT_CONTROL  = 8'b0001_1000;
  localparam logic [7:0] MULTU_CONTROL = 8'b0001_1001;
  localparam logic [7:0] DIV_CONTROL   = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL  = 8'b0001_1011;
  localparam logic [7:0] MADD_CONTROL  = 8'b0001_1100;
  localparam logic [7:0] MADDU_CONTROL = 8'b0001_1101;
  localparam logic [7:0] MSUB_CONTROL  = 8'b0001_1110;
  localparam logic [7:0] MSUBU_CONTROL = 8'b0001_1111;
  localparam logic [7:0] MUL_CONTROL   = 8'b0010_0000;

  function automatic logic is_mul_op(input logic [7:0] c);
    return c inside {MULT_CONTROL, MULTU_CONTROL, MADD_CONTROL, MADDU_CONTROL,
                     MSUB_CONTROL, MSUBU_CONTROL, MUL_CONTROL};
  endfunction

  function automatic logic is_div_op(input logic [7:0] c);
    return c inside {DIV_CONTROL, DIVU_CONTROL};
  endfunction

  function automatic logic is_signed_op(input logic [7:0] c);
    return c inside {MULT_CONTROL, MADD_CONTROL, MSUB_CONTROL, MUL_CONTROL, DIV_CONTROL};
  endfunction
endpackage

interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic [7:0]       alucontrolE;
  logic             valid_i;
  logic             flush_i;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] mul_result_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output alucontrolE, valid_i, flush_i, srcaE, srcbE,
    input  busy_o, done_o, mul_result_o, hi_o, lo_o
  );

  modport slave (
    input  alucontrolE, valid_i, flush_i, srcaE, srcbE,
    output busy_o, done_o, mul_result_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the pipeline while a multi-cycle op is in flight.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  localparam int unsigned CW = 6;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       op;
  logic [WIDTH-1:0] dividend, divisor, quo, rem;
  logic [WIDTH-1:0] hi, lo, mul_result;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, div_zero;
  logic [PW-1:0]    prod_q;
  logic             busy, done;

  logic             fire, mul_op, div_op, sgn;
  logic [PW-1:0]    ext_a, ext_b, prod, acc;
  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]   trial;

  assign fire   = (state == IDLE) && bus.valid_i && !bus.flush_i;
  assign mul_op = is_mul_op(bus.alucontrolE);
  assign div_op = is_div_op(bus.alucontrolE);
  assign sgn    = is_signed_op(bus.alucontrolE);

  // Product is taken from the accept-cycle operands, so later operand changes are irrelevant
  assign ext_a = {{WIDTH{sgn & bus.srcaE[WIDTH-1]}}, bus.srcaE};
  assign ext_b = {{WIDTH{sgn & bus.srcbE[WIDTH-1]}}, bus.srcbE};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi, lo};

  assign mag_a   = (sgn && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
  assign mag_b   = (sgn && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, divisor};
  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = r_neg ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational stall and completion strobes
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          if (mul_op) begin
            busy      = 1'b1;
            state_nxt = (MUL_LAT > 1) ? MUL : DONE;
          end else if (div_op) begin
            busy      = 1'b1;
            state_nxt = (bus.srcbE == '0) ? DONE : DIV;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= '0;
      dividend   <= '0;
      divisor    <= '0;
      quo        <= '0;
      rem        <= '0;
      cnt        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      prod_q     <= '0;
      hi         <= '0;
      lo         <= '0;
      mul_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            if (bus.alucontrolE == MTHI_CONTROL) hi <= bus.srcaE;
            if (bus.alucontrolE == MTLO_CONTROL) lo <= bus.srcaE;
            if (mul_op) begin
              op     <= bus.alucontrolE;
              prod_q <= prod;
              cnt    <= CW'(MUL_LAT - 1);
              if (bus.alucontrolE == MUL_CONTROL) mul_result <= prod[WIDTH-1:0];
            end
            if (div_op) begin
              op       <= bus.alucontrolE;
              dividend <= bus.srcaE;
              divisor  <= mag_b;
              quo      <= mag_a;
              rem      <= '0;
              q_neg    <= sgn & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
              r_neg    <= sgn & bus.srcaE[WIDTH-1];
              div_zero <= (bus.srcbE == '0);
              cnt      <= CW'(WIDTH);
            end
          end
        end
        MUL: cnt <= cnt - CW'(1);
        // Restoring step: quotient bits shift in from the right as dividend bits shift out
        DIV: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        DONE: begin
          if (!bus.flush_i) begin
            case (op)
              MULT_CONTROL, MULTU_CONTROL: {hi, lo} <= prod_q;
              MADD_CONTROL, MADDU_CONTROL: {hi, lo} <= acc + prod_q;
              MSUB_CONTROL, MSUBU_CONTROL: {hi, lo} <= acc - prod_q;
              DIV_CONTROL, DIVU_CONTROL: begin
                if (div_zero) begin
                  lo <= '1;
                  hi <= dividend;
                end else begin
                  lo <= quo_fix;
                  hi <= rem_fix;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.hi_o         = hi;
  assign bus.lo_o         = lo;
  assign bus.mul_result_o = mul_result;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed HI/LO cases, flush/reset aborts and model-checked random ops.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int unsigned W       = 32;
  localparam int          LAT_MUL = 2;
  localparam int          LAT_DIV = 33;
  localparam logic [7:0]  NOP     = 8'h00;

  logic clk = 1'b0;
  logic rst;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv #(.WIDTH(W), .MUL_LAT(LAT_MUL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi, m_lo, m_mul;
  logic [7:0]  ops [7];
  logic [7:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo, r_mul;
  int          r_lat, nd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each done pulse retires the oldest expectation; HI/LO are checked right after that edge
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        @(posedge clk);
        #1;
        chk("hi", 64'(bus.hi_o), 64'(mon_e.hi));
        chk("lo", 64'(bus.lo_o), 64'(mon_e.lo));
        chk("mul_result", 64'(bus.mul_result_o), 64'(mon_e.mul));
      end
    end
  end

  task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] emul);
    exp_t e;
    int   cyc;
    int   nbusy;
    bit   seen;
    e.hi = ehi;
    e.lo = elo;
    e.mul = emul;
    sb.push_back(e);
    tick();
    bus.alucontrolE = op;
    bus.srcaE       = a;
    bus.srcbE       = b;
    bus.valid_i     = 1'b1;
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && cyc <= 40) begin
      #1;
      if (bus.done_o) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, 64'(bus.busy_o), 64'd0);
      end else begin
        if (bus.busy_o) nbusy++;
        tick();
        cyc++;
        bus.srcaE = $urandom;
        bus.srcbE = $urandom;
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat));
    tick();
    bus.valid_i     = 1'b0;
    bus.alucontrolE = NOP;
    #1;
    chk({tag, "_done_once"}, 64'(bus.done_o), 64'd0);
    m_hi  = ehi;
    m_lo  = elo;
    m_mul = emul;
  endtask

  task automatic mt(input string tag, input logic [7:0] op, input logic [31:0] v);
    tick();
    bus.alucontrolE = op;
    bus.srcaE       = v;
    bus.valid_i     = 1'b1;
    #1;
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    tick();
    bus.valid_i     = 1'b0;
    bus.alucontrolE = NOP;
    if (op == MTHI_CONTROL) m_hi = v;
    else                    m_lo = v;
    chk({tag, "_hi"}, 64'(bus.hi_o), 64'(m_hi));
    chk({tag, "_lo"}, 64'(bus.lo_o), 64'(m_lo));
  endtask

  // Reference results from plain SV arithmetic on the current HI/LO model
  task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic [31:0] emul,
                       output int lat);
    longint          sp;
    longint unsigned up, acc, res;
    sp   = longint'($signed(a)) * longint'($signed(b));
    up   = {32'd0, a} * {32'd0, b};
    acc  = {m_hi, m_lo};
    res  = acc;
    emul = m_mul;
    lat  = LAT_MUL;
    case (op)
      MULT_CONTROL:  res = sp;
      MULTU_CONTROL: res = up;
      MADD_CONTROL:  res = acc + sp;
      MSUBU_CONTROL: res = acc - up;
      MUL_CONTROL:   emul = sp[31:0];
      DIV_CONTROL: begin
        lat = LAT_DIV;
        res = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      DIVU_CONTROL: begin
        lat = LAT_DIV;
        res = {a % b, a / b};
      end
      default: ;
    endcase
    ehi = res[63:32];
    elo = res[31:0];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.alucontrolE = NOP;
    bus.srcaE       = '0;
    bus.srcbE       = '0;
    ops = '{MULT_CONTROL, MULTU_CONTROL, MADD_CONTROL, MSUBU_CONTROL, MUL_CONTROL, DIV_CONTROL, DIVU_CONTROL};
    repeat (2) tick();
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_mul", 64'(bus.mul_result_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    rst   = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    m_mul = '0;

    do_op("mult", MULT_CONTROL, 32'hFFFF_FFFF, 32'h2, LAT_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0);
    do_op("multu", MULTU_CONTROL, 32'hFFFF_FFFF, 32'h2, LAT_MUL, 32'h1, 32'hFFFF_FFFE, 32'h0);
    do_op("div_neg", DIV_CONTROL, 32'hFFFF_FFF9, 32'h2, LAT_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0);
    do_op("divu", DIVU_CONTROL, 32'd100, 32'd7, LAT_DIV, 32'd2, 32'd14, 32'h0);
    mt("mthi", MTHI_CONTROL, 32'h0);
    mt("mtlo", MTLO_CONTROL, 32'd10);
    do_op("madd", MADD_CONTROL, 32'd3, 32'd4, LAT_MUL, 32'h0, 32'd22, 32'h0);
    do_op("msubu", MSUBU_CONTROL, 32'hFFFF_FFFF, 32'h1, LAT_MUL, 32'hFFFF_FFFF, 32'h17, 32'h0);
    do_op("mul", MUL_CONTROL, 32'hFFFF_FFFD, 32'd7, LAT_MUL, 32'hFFFF_FFFF, 32'h17, 32'hFFFF_FFEB);
    do_op("div_zero", DIV_CONTROL, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, m_mul);
    do_op("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV, 32'h0, 32'h8000_0000, m_mul);
    mt("mtlo2", MTLO_CONTROL, 32'h1234);

    // Flush on the DONE cycle must drop the write
    tick();
    bus.alucontrolE = MULTU_CONTROL;
    bus.srcaE       = 32'd5;
    bus.srcbE       = 32'd6;
    bus.valid_i     = 1'b1;
    tick();
    tick();
    bus.flush_i = 1'b1;
    #1;
    chk("flush_done_pulse", 64'(bus.done_o), 64'd0);
    tick();
    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.alucontrolE = NOP;
    chk("flush_done_hi", 64'(bus.hi_o), 64'(m_hi));
    chk("flush_done_lo", 64'(bus.lo_o), 64'(m_lo));

    // Flush in the middle of a divide
    tick();
    bus.alucontrolE = DIV_CONTROL;
    bus.srcaE       = 32'd1000;
    bus.srcbE       = 32'd3;
    bus.valid_i     = 1'b1;
    repeat (10) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.alucontrolE = NOP;
    #1;
    chk("flush_div_busy", 64'(bus.busy_o), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done_o) nd++;
    end
    chk("flush_div_no_done", 64'(nd), 64'd0);
    chk("flush_div_hi", 64'(bus.hi_o), 64'(m_hi));
    chk("flush_div_lo", 64'(bus.lo_o), 64'(m_lo));

    for (int i = 0; i < 10; i++) begin
      r_op = ops[$urandom_range(0, 6)];
      r_a  = $urandom;
      r_b  = $urandom;
      if (r_op == DIV_CONTROL || r_op == DIVU_CONTROL) begin
        r_b = r_b >> $urandom_range(0, 28);
        if (r_b == 32'd0 || (r_op == DIV_CONTROL && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF))
          r_b = 32'd1;
      end
      model(r_op, r_a, r_b, r_hi, r_lo, r_mul, r_lat);
      do_op("rand", r_op, r_a, r_b, r_lat, r_hi, r_lo, r_mul);
    end

    // Synchronous reset in the middle of a divide
    mt("mthi_pre_rst", MTHI_CONTROL, 32'hA5A5_0001);
    tick();
    bus.alucontrolE = DIV_CONTROL;
    bus.srcaE       = 32'd1000;
    bus.srcbE       = 32'd3;
    bus.valid_i     = 1'b1;
    repeat (5) tick();
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.alucontrolE = NOP;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_mid_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done_o) nd++;
    end
    chk("rst_mid_no_done", 64'(nd), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
